// File: rtl/output_config_regs.sv
// LED output channel configuration registers with POV frame timer.
// Per-channel page/frame-address sequencing driven by the timer tick.
module output_config_regs #(
  parameter int          OUTPUT_COUNT       = 3,
  parameter logic [15:0] CONFIG_BASE        = 16'hFF00,
  parameter logic [7:0]  POV_PRESCALE_RESET = 8'd1,
  parameter logic [15:0] POV_COUNTER_RESET  = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                address,
  input  logic [15:0]                write_data,
  input  logic                       write_strobe,
  input  logic                       read_strobe,
  output logic [15:0]                read_data,
  output logic                       read_valid,
  output logic [OUTPUT_COUNT-1:0]    output_enables,
  output logic [3*OUTPUT_COUNT-1:0]  protocols,
  output logic [8*OUTPUT_COUNT-1:0]  page_counts,
  output logic [OUTPUT_COUNT-1:0]    double_pixels,
  output logic [2*OUTPUT_COUNT-1:0]  clock_divisors,
  output logic [16*OUTPUT_COUNT-1:0] word_counts,
  output logic [16*OUTPUT_COUNT-1:0] frame_addresses,
  output logic [OUTPUT_COUNT-1:0]    start_strobes
);

  localparam int N = OUTPUT_COUNT;

  logic                 hit;
  logic [3:0]           grp;
  logic [3:0]           idx;
  logic                 gwr;
  logic                 twr;
  logic                 tick;

  logic [N-1:0]         en_q, en_d;
  logic [15:0]          cpre_q, cpre_d;
  logic [7:0]           ppre_q, ppre_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [7:0]           pre_q, pre_d;
  logic [15:0]          frame_q, frame_d;
  logic [N-1:0][2:0]    proto_q, proto_d;
  logic [N-1:0][7:0]    pages_q, pages_d;
  logic [N-1:0]         dbl_q, dbl_d;
  logic [N-1:0][1:0]    div_q, div_d;
  logic [N-1:0][15:0]   wc_q, wc_d;
  logic [N-1:0][15:0]   sa_q, sa_d;
  logic [N-1:0][7:0]    page_q, page_d;
  logic [N-1:0][15:0]   fa_q, fa_d;
  logic [N-1:0]         stb_q, stb_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic [15:0]          rd;

  assign hit = address[15:8] == CONFIG_BASE[15:8];
  assign grp = address[7:4];
  assign idx = address[3:0];
  assign gwr = write_strobe && hit && grp == 4'd0;
  assign twr = gwr && (idx == 4'd1 || idx == 4'd2);

  // Timer, register writes and per-channel page sequencing.
  always_comb begin
    en_d    = en_q;
    cpre_d  = cpre_q;
    ppre_d  = ppre_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    frame_d = frame_q;
    proto_d = proto_q;
    pages_d = pages_q;
    dbl_d   = dbl_q;
    div_d   = div_q;
    wc_d    = wc_q;
    sa_d    = sa_q;
    page_d  = page_q;
    fa_d    = fa_q;
    stb_d   = '0;
    tick    = 1'b0;

    if (gwr && idx == 4'd0) en_d = write_data[N-1:0];
    if (gwr && idx == 4'd1) cpre_d = write_data;
    if (gwr && idx == 4'd2) ppre_d = write_data[7:0];

    if (twr) begin
      pre_d = ppre_d;
      cnt_d = cpre_d;
    end else if (pre_q != 8'd0) begin
      pre_d = pre_q - 8'd1;
    end else if (cnt_q != 16'd0) begin
      pre_d = ppre_q;
      cnt_d = cnt_q - 16'd1;
    end else begin
      pre_d = ppre_q;
      cnt_d = cpre_q;
      tick  = 1'b1;
    end
    if (tick) frame_d = frame_q + 16'd1;

    for (int i = 0; i < N; i++) begin
      logic cw, ww, sw;
      cw = write_strobe && hit && grp == 4'd1 && idx == 4'(i);
      ww = write_strobe && hit && grp == 4'd2 && idx == 4'(i);
      sw = write_strobe && hit && grp == 4'd3 && idx == 4'(i);
      if (cw) begin
        {proto_d[i], pages_d[i], dbl_d[i], div_d[i]} = write_data[13:0];
      end
      if (ww) wc_d[i] = write_data;
      if (sw) sa_d[i] = write_data;
      if (cw || sw) begin
        page_d[i] = 8'd0;
        fa_d[i]   = sa_d[i];
      end else if (!en_q[i]) begin
        page_d[i] = 8'd0;
        fa_d[i]   = sa_q[i];
      end else if (tick) begin
        stb_d[i] = 1'b1;
        if (pages_q[i] <= 8'd1 ||
            ({1'b0, page_q[i]} + 9'd1) >= {1'b0, pages_q[i]}) begin
          page_d[i] = 8'd0;
          fa_d[i]   = sa_q[i];
        end else begin
          page_d[i] = page_q[i] + 8'd1;
          fa_d[i]   = fa_q[i] + wc_q[i];
        end
      end
    end
  end

  // Readback mux; samples pre-write state so read+write returns old value.
  always_comb begin
    rd = 16'h0000;
    if (hit) begin
      case (grp)
        4'd0: begin
          case (idx)
            4'd0:    rd = 16'(en_q);
            4'd1:    rd = cpre_q;
            4'd2:    rd = {8'h00, ppre_q};
            4'd3:    rd = frame_q;
            default: rd = 16'h0000;
          endcase
        end
        default: begin
          for (int i = 0; i < N; i++) begin
            if (idx == 4'(i)) begin
              if (grp == 4'd1)
                rd = {2'b00, proto_q[i], pages_q[i], dbl_q[i], div_q[i]};
              else if (grp == 4'd2)
                rd = wc_q[i];
              else if (grp == 4'd3)
                rd = sa_q[i];
            end
          end
        end
      endcase
    end
    rdata_d  = read_strobe ? rd : 16'h0000;
    rvalid_d = read_strobe;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q     <= '0;
      cpre_q   <= POV_COUNTER_RESET;
      ppre_q   <= POV_PRESCALE_RESET;
      cnt_q    <= POV_COUNTER_RESET;
      pre_q    <= POV_PRESCALE_RESET;
      frame_q  <= '0;
      proto_q  <= '0;
      pages_q  <= '0;
      dbl_q    <= '0;
      div_q    <= '0;
      wc_q     <= '0;
      sa_q     <= '0;
      page_q   <= '0;
      fa_q     <= '0;
      stb_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      en_q     <= en_d;
      cpre_q   <= cpre_d;
      ppre_q   <= ppre_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      frame_q  <= frame_d;
      proto_q  <= proto_d;
      pages_q  <= pages_d;
      dbl_q    <= dbl_d;
      div_q    <= div_d;
      wc_q     <= wc_d;
      sa_q     <= sa_d;
      page_q   <= page_d;
      fa_q     <= fa_d;
      stb_q    <= stb_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign read_data       = rdata_q;
  assign read_valid      = rvalid_q;
  assign output_enables  = en_q;
  assign protocols       = proto_q;
  assign page_counts     = pages_q;
  assign double_pixels   = dbl_q;
  assign clock_divisors  = div_q;
  assign word_counts     = wc_q;
  assign frame_addresses = fa_q;
  assign start_strobes   = stb_q;

endmodule

// File: tb/tb_output_config_regs.sv
// Bench for output_config_regs: register table, readback scoreboard,
// POV timer / page sequencing corner cases and reset.
module tb_output_config_regs;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   address = '0;
  logic [15:0]   write_data = '0;
  logic          write_strobe = 1'b0;
  logic          read_strobe = 1'b0;
  logic [15:0]   read_data;
  logic          read_valid;
  logic [N-1:0]  output_enables;
  logic [3*N-1:0]  protocols;
  logic [8*N-1:0]  page_counts;
  logic [N-1:0]    double_pixels;
  logic [2*N-1:0]  clock_divisors;
  logic [16*N-1:0] word_counts;
  logic [16*N-1:0] frame_addresses;
  logic [N-1:0]    start_strobes;

  output_config_regs dut (
    .clk             (clk),
    .rst             (rst),
    .address         (address),
    .write_data      (write_data),
    .write_strobe    (write_strobe),
    .read_strobe     (read_strobe),
    .read_data       (read_data),
    .read_valid      (read_valid),
    .output_enables  (output_enables),
    .protocols       (protocols),
    .page_counts     (page_counts),
    .double_pixels   (double_pixels),
    .clock_divisors  (clock_divisors),
    .word_counts     (word_counts),
    .frame_addresses (frame_addresses),
    .start_strobes   (start_strobes)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [15:0] raddr;
    logic [15:0] rexp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: each readback must match the oldest pending expectation.
  always @(negedge clk) begin
    if (read_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got valid data %h want none",
                 read_data);
      end else begin
        chk("readback", {16'h0, read_data}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address = a;
    write_data = d;
    write_strobe = 1'b1;
    cyc();
    write_strobe = 1'b0;
  endtask

  task automatic rdq(input logic [15:0] a, input logic [15:0] e);
    address = a;
    read_strobe = 1'b1;
    sb.push_back(e);
    cyc();
    read_strobe = 1'b0;
  endtask

  // Wait for a ch0 strobe; optionally issue a read in the first cycle.
  task automatic wait_stb(input logic do_rd, input logic [15:0] ra,
                          input logic [15:0] re, output int n);
    n = 0;
    if (do_rd) begin
      address = ra;
      read_strobe = 1'b1;
      sb.push_back(re);
    end
    do begin
      cyc();
      read_strobe = 1'b0;
      n++;
    end while (!start_strobes[0] && n < 20);
    if (!start_strobes[0]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stb_timeout: got no strobe want strobe in 20");
    end
  endtask

  logic [15:0] fa_exp[4];
  int n;

  initial begin
    tbl[0]  = '{16'hFF10, 16'hFFFF, 16'hFF10, 16'h3FFF};
    tbl[1]  = '{16'hFF11, 16'h1234, 16'hFF11, 16'h1234};
    tbl[2]  = '{16'hFF21, 16'hBEEF, 16'hFF21, 16'hBEEF};
    tbl[3]  = '{16'hFF32, 16'hCAFE, 16'hFF32, 16'hCAFE};
    tbl[4]  = '{16'hFF13, 16'h5555, 16'hFF13, 16'h0000};
    tbl[5]  = '{16'hFF03, 16'h7777, 16'hFF03, 16'h0000};
    tbl[6]  = '{16'hFF04, 16'h1111, 16'hFF04, 16'h0000};
    tbl[7]  = '{16'hFE10, 16'h2222, 16'hFF10, 16'h3FFF};
    tbl[8]  = '{16'hFF12, 16'h4000, 16'hFF12, 16'h0000};
    tbl[9]  = '{16'hFF00, 16'hFFFF, 16'hFF00, 16'h0007};
    tbl[10] = '{16'hFF02, 16'h01AB, 16'hFF02, 16'h00AB};
    tbl[11] = '{16'hFF00, 16'h0000, 16'hFF00, 16'h0000};
    fa_exp = '{16'h0140, 16'h0180, 16'h0100, 16'h0140};

    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_outs", {31'h0, |{output_enables, protocols, page_counts,
        double_pixels, clock_divisors, word_counts, frame_addresses,
        start_strobes, read_data, read_valid}}, 32'h0);
    rdq(16'hFF01, 16'hFFFF);
    rdq(16'hFF02, 16'h0001);

    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      rdq(tbl[i].raddr, tbl[i].rexp);
    end
    chk("proto0", {29'h0, protocols[2:0]}, 32'h7);
    chk("pages0", {24'h0, page_counts[7:0]}, 32'hFF);
    chk("proto1", {29'h0, protocols[5:3]}, 32'h2);
    chk("pages1", {24'h0, page_counts[15:8]}, 32'h46);
    chk("dbl", {29'h0, double_pixels}, 32'h3);
    chk("div", {26'h0, clock_divisors}, 32'h3);
    chk("wc1", {16'h0, word_counts[31:16]}, 32'hBEEF);
    chk("fa2_dis", {16'h0, frame_addresses[47:32]}, 32'hCAFE);

    rdq(16'hFF1F, 16'h0000);
    address = 16'hFF20;
    write_data = 16'h0ABC;
    write_strobe = 1'b1;
    read_strobe = 1'b1;
    sb.push_back(16'h0000);
    cyc();
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    rdq(16'hFF20, 16'h0ABC);

    wr(16'hFF30, 16'h0100);
    wr(16'hFF20, 16'h0040);
    wr(16'hFF10, 16'h0018);
    chk("fa0_start", {16'h0, frame_addresses[15:0]}, 32'h0100);
    wr(16'hFF01, 16'h0003);
    wr(16'hFF02, 16'h0001);
    wr(16'hFF00, 16'h0001);
    for (int s = 0; s < 4; s++) begin
      wait_stb(s != 0, 16'hFF03, 16'(s), n);
      chk($sformatf("period%0d", s), n, (s == 0) ? 7 : 8);
      chk($sformatf("fa_seq%0d", s), {16'h0, frame_addresses[15:0]},
          {16'h0, fa_exp[s]});
    end
    chk("stb_other", {29'h0, start_strobes[2:1]}, 32'h0);

    repeat (7) cyc();
    chk("pre_tick_nostb", {31'h0, start_strobes[0]}, 32'h0);
    wr(16'hFF30, 16'h0200);
    chk("wr_tick_stb", {31'h0, start_strobes[0]}, 32'h0);
    chk("wr_tick_fa", {16'h0, frame_addresses[15:0]}, 32'h0200);
    wait_stb(1'b1, 16'hFF03, 16'h0005, n);
    chk("wr_tick_period", n, 8);
    chk("wr_tick_page0", {16'h0, frame_addresses[15:0]}, 32'h0240);

    wr(16'hFF30, 16'hFFF0);
    wr(16'hFF20, 16'h0020);
    wr(16'hFF10, 16'h0010);
    wait_stb(1'b0, 16'h0, 16'h0, n);
    chk("wrap_fa", {16'h0, frame_addresses[15:0]}, 32'h0010);
    wait_stb(1'b0, 16'h0, 16'h0, n);
    chk("wrap_period", n, 8);
    chk("wrap_back", {16'h0, frame_addresses[15:0]}, 32'hFFF0);

    repeat (3) cyc();
    rst = 1'b0;
    address = 16'hFF00;
    write_data = 16'hFFFF;
    write_strobe = 1'b1;
    read_strobe = 1'b1;
    cyc();
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    chk("midrst_outs", {31'h0, |{output_enables, protocols, page_counts,
        double_pixels, clock_divisors, word_counts, frame_addresses,
        start_strobes, read_data, read_valid}}, 32'h0);
    rst = 1'b1;
    rdq(16'hFF01, 16'hFFFF);
    rdq(16'hFF02, 16'h0001);
    rdq(16'hFF03, 16'h0000);
    rdq(16'hFF30, 16'h0000);
    repeat (12) cyc();
    chk("no_tick_after_rst", {31'h0, |start_strobes}, 32'h0);

    repeat (3) cyc();
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
